// File: rtl/countdown_timer.sv
// MM:SS countdown timer with set/run/pause/expired control and BCD outputs.
// Define COUNTDOWN_ALARM_EN to add the 1 Hz blinking alarm in EXPIRED.
module countdown_timer #(
  parameter int CLOCK_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       inc_sec,
  input  logic       inc_min,
  output logic [3:0] sec1,
  output logic [3:0] sec2,
  output logic [3:0] min1,
  output logic [3:0] min2,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  localparam int PW = (CLOCK_CYCLES > 2) ? $clog2(CLOCK_CYCLES) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    EXPIRED
  } state_t;

  state_t state, state_nxt;

  logic [PW-1:0] presc;
  logic          tick;
  logic          is_zero;
  logic          is_one;
  logic [3:0]    s1_inc, s2_inc, m1_inc, m2_inc;
  logic [3:0]    s1_dec, s2_dec, m1_dec, m2_dec;

  assign tick    = (presc == LAST);
  assign is_zero = ({min2, min1, sec2, sec1} == 16'h0000);
  assign is_one  = ({min2, min1, sec2, sec1} == 16'h0001);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start && !is_zero) state_nxt = RUN;
        RUN: begin
          if (pause)              state_nxt = PAUSED;
          else if (tick && is_one) state_nxt = EXPIRED;
        end
        PAUSED:  if (start) state_nxt = RUN;
        EXPIRED: state_nxt = EXPIRED;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    running = (state == RUN);
    done    = (state == EXPIRED);
`ifdef COUNTDOWN_ALARM_EN
    alarm   = (state == EXPIRED) && (presc < PW'(CLOCK_CYCLES / 2));
`else
    alarm   = 1'b0;
`endif
  end

  // Set-mode increments: each field wraps at 59 with no carry between them
  always_comb begin
    s1_inc = sec1 + 4'd1;
    s2_inc = sec2;
    if (sec1 == 4'd9) begin
      s1_inc = 4'd0;
      s2_inc = (sec2 == 4'd5) ? 4'd0 : sec2 + 4'd1;
    end
    m1_inc = min1 + 4'd1;
    m2_inc = min2;
    if (min1 == 4'd9) begin
      m1_inc = 4'd0;
      m2_inc = (min2 == 4'd5) ? 4'd0 : min2 + 4'd1;
    end
  end

  // One-second BCD decrement with a full borrow chain
  always_comb begin
    s1_dec = sec1 - 4'd1;
    s2_dec = sec2;
    m1_dec = min1;
    m2_dec = min2;
    if (sec1 == 4'd0) begin
      s1_dec = 4'd9;
      s2_dec = sec2 - 4'd1;
      if (sec2 == 4'd0) begin
        s2_dec = 4'd5;
        m1_dec = min1 - 4'd1;
        if (min1 == 4'd0) begin
          m1_dec = 4'd9;
          m2_dec = min2 - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      presc <= '0;
      sec1  <= 4'd0;
      sec2  <= 4'd0;
      min1  <= 4'd0;
      min2  <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          presc <= '0;
          if (inc_sec) begin
            sec1 <= s1_inc;
            sec2 <= s2_inc;
          end
          if (inc_min) begin
            min1 <= m1_inc;
            min2 <= m2_inc;
          end
        end
        RUN: begin
          if (!pause) begin
            if (tick) begin
              presc <= '0;
              sec1  <= s1_dec;
              sec2  <= s2_dec;
              min1  <= m1_dec;
              min2  <= m2_dec;
            end else begin
              presc <= presc + 1'b1;
            end
          end
        end
        PAUSED: begin
          presc <= presc;
        end
        EXPIRED: begin
`ifdef COUNTDOWN_ALARM_EN
          presc <= tick ? '0 : presc + 1'b1;
`else
          presc <= '0;
`endif
        end
        default: presc <= '0;
      endcase
    end
  end

endmodule
